// File: rtl/tristate_drv_pkg.sv
// tristate_drv_pkg
//   Shared definitions for tristate_shift_driver: the FSM state encoding
//   and the sizing function for the per-state cycle counter.
package tristate_drv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      SHIFT = 2'd2,
      TURN  = 2'd3
   } drv_state_t;

   // Counter width large enough to hold the longest state length
   // (max of preamble, data and turnaround cycle counts) without wrapping.
   function automatic int cnt_width(input int width, input int lead_cyc,
                                    input int turn_cyc);
      int m;
      m = width;
      if (lead_cyc > m) m = lead_cyc;
      if (turn_cyc > m) m = turn_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tristate_shift_driver.sv
// tristate_shift_driver
//   Serialises a parallel word onto a bidirectional pad through an external
//   tri-state buffer: a drive-high preamble, the word LSB first, then a
//   released turnaround before the next word may be accepted.
//
// Parameters
//   WIDTH     data word width (>= 2)
//   LEAD_CYC  drive-high preamble cycles before data (>= 1)
//   TURN_CYC  released turnaround cycles after each word (>= 0)
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   DIN        parallel word to transmit
//   DIN_VALID  DIN holds a valid word
//   DIN_READY  word accepted on this edge if DIN_VALID is also high
//   ABORT      terminate the current transfer (LEAD/SHIFT only)
//   O          serial data to the buffer data input (registered)
//   T          buffer enable, 1 = released / high-Z (registered)
//   BUSY       transfer or turnaround in progress (registered)
//   DONE       one-cycle pulse after the last data bit (registered)
module tristate_shift_driver
   import tristate_drv_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int LEAD_CYC = 1,
   parameter int TURN_CYC = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   input  logic             ABORT,
   output logic             O,
   output logic             T,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CW = cnt_width(WIDTH, LEAD_CYC, TURN_CYC);

   localparam logic [CW-1:0] LEAD_LAST  = CW'(LEAD_CYC - 1);
   localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] TURN_LAST  = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

   // With no turnaround the TURN state is skipped entirely.
   localparam drv_state_t AFTER_SHIFT = (TURN_CYC > 0) ? TURN : IDLE;
   localparam logic       BUSY_AFTER  = (TURN_CYC > 0);

   drv_state_t       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic             o_nxt, t_nxt, busy_nxt, done_nxt;

   assign DIN_READY = (state == IDLE) && !ABORT;

   // Outputs are computed for the state being entered, then registered, so
   // O/T/BUSY/DONE always line up with the state they describe.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      o_nxt     = 1'b0;
      t_nxt     = 1'b1;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;

      unique case (state)
         IDLE: begin
            if (DIN_VALID && DIN_READY) begin
               state_nxt = LEAD;
               cnt_nxt   = '0;
               shreg_nxt = DIN;
               o_nxt     = 1'b1;
               t_nxt     = 1'b0;
               busy_nxt  = 1'b1;
            end
         end

         LEAD: begin
            if (ABORT) begin
               state_nxt = AFTER_SHIFT;
               cnt_nxt   = '0;
               shreg_nxt = '0;
               busy_nxt  = BUSY_AFTER;
            end else begin
               t_nxt    = 1'b0;
               busy_nxt = 1'b1;
               if (cnt == LEAD_LAST) begin
                  // First data bit goes out in the first SHIFT cycle.
                  state_nxt = SHIFT;
                  cnt_nxt   = '0;
                  o_nxt     = shreg[0];
                  shreg_nxt = shreg >> 1;
               end else begin
                  cnt_nxt = cnt + CW'(1);
                  o_nxt   = 1'b1;
               end
            end
         end

         SHIFT: begin
            if (ABORT) begin
               state_nxt = AFTER_SHIFT;
               cnt_nxt   = '0;
               shreg_nxt = '0;
               busy_nxt  = BUSY_AFTER;
            end else if (cnt == SHIFT_LAST) begin
               state_nxt = AFTER_SHIFT;
               cnt_nxt   = '0;
               busy_nxt  = BUSY_AFTER;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt + CW'(1);
               o_nxt     = shreg[0];
               shreg_nxt = shreg >> 1;
               t_nxt     = 1'b0;
               busy_nxt  = 1'b1;
            end
         end

         TURN: begin
            // ABORT is deliberately ignored here: the pad is already released.
            if (cnt == TURN_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt  = cnt + CW'(1);
               busy_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         O     <= 1'b0;
         T     <= 1'b1;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
         O     <= o_nxt;
         T     <= t_nxt;
         BUSY  <= busy_nxt;
         DONE  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_tristate_shift_driver.sv
// tb_tristate_shift_driver
//   Directed bench for tristate_shift_driver. Expected serial bits are queued
//   when a word is issued; a negedge monitor pops them whenever the pad is
//   driven and also accounts for every DONE pulse. A second instance covers
//   the LEAD_CYC=3 / TURN_CYC=0 configuration.
module tb_tristate_shift_driver;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] din;
   logic       din_valid, abort;
   logic       din_ready, o, t, busy, done;

   logic [7:0] din2;
   logic       din_valid2, abort2;
   logic       din_ready2, o2, t2, busy2, done2;

   always #5 CLK = ~CLK;

   tristate_shift_driver #(.WIDTH(8), .LEAD_CYC(1), .TURN_CYC(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .DIN(din), .DIN_VALID(din_valid),
      .DIN_READY(din_ready), .ABORT(abort), .O(o), .T(t), .BUSY(busy),
      .DONE(done)
   );

   tristate_shift_driver #(.WIDTH(8), .LEAD_CYC(3), .TURN_CYC(0)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .DIN(din2), .DIN_VALID(din_valid2),
      .DIN_READY(din_ready2), .ABORT(abort2), .O(o2), .T(t2), .BUSY(busy2),
      .DONE(done2)
   );

   logic exp_q[$];
   int   done_exp = 0;
   int   acc_cyc[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // seq holds the expected pad bits first-to-last from bit n-1 down to 0.
   task automatic push_bits(input logic [8:0] seq, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(seq[i]);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && !din_ready; i++) tick();
      chk("idle_reached", din_ready, 1);
   endtask

   always @(posedge CLK) begin
      if (RST_N && din_valid && din_ready) acc_cyc.push_back(cyc);
      cyc++;
   end

   // Scoreboard monitor for the main instance.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (!t) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_drive: got T=0 O=%0b, expected T=1 (t=%0t)", o, $time);
            end else begin
               chk("serial_o", o, exp_q.pop_front());
            end
         end else begin
            chk("released_o_low", o, 0);
         end
         if (done) begin
            n_checks++;
            if (done_exp > 0) begin
               done_exp--;
               n_pass++;
            end else begin
               $display("FAIL unexpected_done: got DONE=1, expected 0 (t=%0t)", $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, a;
      logic [10:0] seq2;

      RST_N = 1'b0;
      din = '0; din_valid = 1'b0; abort = 1'b0;
      din2 = '0; din_valid2 = 1'b0; abort2 = 1'b0;
      tick(); tick();
      chk("rst_t", t, 1);
      chk("rst_o", o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      RST_N = 1'b1;
      tick();

      // Basic transfer of A5.
      din = 8'hA5; din_valid = 1'b1;
      push_bits(9'b1_10100101, 9); done_exp++;
      tick(); din_valid = 1'b0;                  // cycle 1
      chk("basic_busy", busy, 1);
      chk("basic_lead_t", t, 0);
      chk("basic_ready_low", din_ready, 0);
      repeat (8) tick();                         // cycle 9
      chk("basic_no_early_done", done, 0);
      tick();                                    // cycle 10
      chk("basic_done_c10", done, 1);
      chk("basic_turn_t_c10", t, 1);
      chk("basic_turn_busy_c10", busy, 1);
      tick();                                    // cycle 11
      chk("basic_turn_t_c11", t, 1);
      chk("basic_done_one_cycle", done, 0);
      tick();                                    // cycle 12
      chk("basic_ready_c12", din_ready, 1);
      chk("basic_idle_busy", busy, 0);

      // Back-to-back with DIN_VALID held high.
      din = 8'hFF; din_valid = 1'b1;
      push_bits(9'b1_11111111, 9); done_exp++;
      n0 = acc_cyc.size();
      tick();
      din = 8'h00;
      push_bits(9'b1_00000000, 9); done_exp++;
      chk("b2b_first_accept", acc_cyc.size(), n0 + 1);
      a = acc_cyc[acc_cyc.size() - 1];
      repeat (9) tick();
      chk("b2b_gap_t1", t, 1);
      tick();
      chk("b2b_gap_t2", t, 1);
      tick();
      chk("b2b_ready", din_ready, 1);
      tick(); din_valid = 1'b0;
      chk("b2b_second_accept", acc_cyc.size(), n0 + 2);
      chk("b2b_period", acc_cyc[acc_cyc.size() - 1] - a, 12);
      wait_idle();

      // Abort in the 4th SHIFT cycle of 3C.
      din = 8'h3C; din_valid = 1'b1;
      push_bits(9'b0000_10011, 5);
      tick(); din_valid = 1'b0;                  // cycle 1
      repeat (4) tick();                         // cycle 5
      abort = 1'b1;
      tick(); abort = 1'b0;                      // cycle 6
      chk("abort_t", t, 1);
      chk("abort_o", o, 0);
      chk("abort_turn_busy", busy, 1);
      tick();                                    // cycle 7
      chk("abort_turn2_t", t, 1);
      chk("abort_turn2_busy", busy, 1);
      tick();                                    // cycle 8
      chk("abort_ready", din_ready, 1);
      chk("abort_idle_busy", busy, 0);
      din = 8'h81; din_valid = 1'b1;
      push_bits(9'b1_10000001, 9); done_exp++;
      tick(); din_valid = 1'b0;
      chk("abort_reaccept_busy", busy, 1);
      wait_idle();

      // ABORT and DIN_VALID together in IDLE.
      abort = 1'b1; din_valid = 1'b1; din = 8'h55;
      #1;
      chk("idle_abort_ready", din_ready, 0);
      n0 = acc_cyc.size();
      repeat (3) begin
         tick();
         chk("idle_abort_t", t, 1);
         chk("idle_abort_busy", busy, 0);
      end
      chk("idle_abort_no_accept", acc_cyc.size(), n0);
      abort = 1'b0; din_valid = 1'b0;
      tick();

      // Reset mid-SHIFT, then acceptance on the first edge after release.
      din = 8'hC3; din_valid = 1'b1;
      push_bits(9'b0000000_11, 2);
      tick(); din_valid = 1'b0;                  // cycle 1
      tick(); tick();                            // cycle 3
      #1;
      chk("pre_reset_t", t, 0);
      RST_N = 1'b0;
      #1;
      chk("async_rst_t", t, 1);
      chk("async_rst_o", o, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      tick();
      chk("rst_hold_t", t, 1);
      @(negedge CLK); #1;
      RST_N = 1'b1;
      din = 8'h01; din_valid = 1'b1;
      push_bits(9'b1_10000000, 9); done_exp++;
      n0 = acc_cyc.size();
      tick(); din_valid = 1'b0;
      chk("post_rst_accept", acc_cyc.size(), n0 + 1);
      chk("post_rst_lead_t", t, 0);
      wait_idle();

      // LEAD_CYC=3, TURN_CYC=0 instance with 96.
      seq2 = 11'b111_01101001;
      din2 = 8'h96; din_valid2 = 1'b1;
      tick(); din_valid2 = 1'b0;                 // cycle 1
      for (int i = 0; i < 11; i++) begin
         chk("d2_o", o2, seq2[10 - i]);
         chk("d2_t", t2, 0);
         chk("d2_no_done", done2, 0);
         tick();
      end                                        // cycle 12
      chk("d2_idle_t", t2, 1);
      chk("d2_idle_busy", busy2, 0);
      chk("d2_done_c12", done2, 1);
      chk("d2_ready_c12", din_ready2, 1);
      tick();
      chk("d2_done_one_cycle", done2, 0);

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("done_all_seen", done_exp, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
